addsub_accum: RTL and testbench
===============================

Name: addsub_accum

Overview:
Parametrised, registered successor to the 4-bit combinational add/subtract unit. It is WIDTH bits wide and has an optional saturation mode. It adds an accumulator operand mode, sticky overflow flags and a valid/ready handshake on both sides. It sits between an operand source and a result consumer in the datapath, with one result register stage.

Parameters:
WIDTH, 4, operand/result width in bits (>= 2)
SAT_MODE, 0, 0 = wrap-around, 1 = unsigned saturation, 2 = signed saturation

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
In_Valid  input  1  operand beat valid
In_Ready  output  1  block can accept an operand beat this cycle
S  input  1  0 = add (A+B), 1 = subtract (A-B)
Acc  input  1  1 = use accumulator instead of A as first operand
A  input  WIDTH  first operand
B  input  WIDTH  second operand
Clear  input  1  zero accumulator and sticky flags
Out_Valid  output  1  result register holds an unconsumed result
Out_Ready  input  1  consumer accepts result this cycle
F  output  WIDTH  result (wrapped or saturated per SAT_MODE)
Unsigned_Overflow  output  1  carry-out on add / borrow on subtract, for the result in F
Signed_Overflow  output  1  two's-complement overflow, for the result in F
Sticky_Unsigned  output  1  OR of all Unsigned_Overflow since last Clear/reset
Sticky_Signed  output  1  OR of all Signed_Overflow since last Clear/reset

Behaviour:
- Reset (rst=1 at edge): Out_Valid=0, F=0, both overflow flags 0, both sticky flags 0, accumulator=0. Reset mid-transaction discards the held result with no output beat.
- In_Ready = !Out_Valid || Out_Ready (combinational, one-entry pipeline with pass-through on pop).
- Accept occurs when In_Valid && In_Ready at the edge. Latency is 1: the result appears in F with Out_Valid=1 on the next cycle.
- Pop occurs when Out_Valid && Out_Ready. Pop and accept in the same cycle reload the register with the new result, and Out_Valid stays 1.
- Pop without accept clears Out_Valid. F and the flags hold their last values while Out_Valid=0.
- Out_Valid=1 && !Out_Ready: F, the flags and Out_Valid are held stable. In_Ready=0.
- Operand X = Acc ? accumulator : A.
- Raw sum is computed in WIDTH+1 bits: add = X + B, sub = X + ~B + 1.
- Unsigned_Overflow: add = carry-out bit WIDTH; sub = borrow, i.e. X < B unsigned (inverted carry-out).
- Signed_Overflow: add = sign(X)==sign(B) && sign(R)!=sign(X); sub = sign(X)!=sign(B) && sign(R)!=sign(X). R is the wrapped WIDTH-bit result.
- SAT_MODE=0: F = R.
- SAT_MODE=1: on unsigned overflow, F = all-ones for add and 0 for sub.
- SAT_MODE=2: on signed overflow, F = max positive (0111..) if sign(X)=0, else min negative (1000..).
- Flags always report the raw overflow, whichever SAT_MODE is selected.
- Accumulator is loaded with F (post-saturation) on every accept.
- Sticky flags OR in the new flags on every accept.
- Clear on a cycle without accept: accumulator=0 and sticky flags=0. Out_Valid, F and the per-result flags are unaffected.
- Clear on the same cycle as an accept:
  - The operation uses accumulator=0 if Acc=1.
  - The accumulator loads the new F.
  - The stickies take only the new op's flags.
- rst has priority over Clear and over accept.

Test Plan:
- WIDTH=4, SAT_MODE=0, Out_Ready=1: S=0, A=3, B=2 -> next cycle F=5, Out_Valid=1, both flags 0. Then S=1, A=3, B=2 -> F=1, flags 0.
- Overflow corners (WIDTH=4, SAT_MODE=0):
  - 7+1 -> F=8, Signed=1, Unsigned=0.
  - 15+1 -> F=0, Unsigned=1, Signed=0.
  - 2-3 -> F=15, Unsigned=1, Signed=0.
  - 8-1 -> F=7, Signed=1.
  - Afterwards Sticky_Unsigned=1 and Sticky_Signed=1.
- Backpressure: hold Out_Ready=0 after the first accept -> In_Ready=0, F stable for 5 cycles, a second In_Valid beat is not taken. Raise Out_Ready with In_Valid=1 -> same-cycle pop+accept, Out_Valid stays 1, next F is the new result.
- Accumulate: Clear, then Acc=1 S=0 B=3 four times -> F = 3, 6, 9, 12. Then Acc=1 S=1 B=13 -> F=15, Unsigned=1. Clear concurrent with Acc=1 B=4 -> F=4, stickies reflect only that op.
- Saturation:
  - SAT_MODE=1: 12+6 -> F=15, Unsigned=1; 2-5 -> F=0.
  - SAT_MODE=2: 6+5 -> F=7, Signed=1; 9-3 (i.e. -7-3) -> F=8.
- Reset mid-operation: assert rst with Out_Valid=1 and Out_Ready=0 -> next cycle Out_Valid=0, F=0, all flags and accumulator 0, In_Ready=1.

Source files
------------

// File: rtl/addsub_accum.sv
// Registered WIDTH-bit add/subtract unit with accumulator operand, optional saturation,
// sticky overflow flags and a one-entry valid/ready output register.
module addsub_accum #(
  parameter int WIDTH    = 4,
  parameter int SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             S,
  input  logic             Acc,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Clear,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] F,
  output logic             Unsigned_Overflow,
  output logic             Signed_Overflow,
  output logic             Sticky_Unsigned,
  output logic             Sticky_Signed
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] x_op, b_op, r, f_next;
  logic [WIDTH:0]   raw;
  logic             accept, pop, uov, sov;

  assign In_Ready = !Out_Valid || Out_Ready;
  assign accept   = In_Valid && In_Ready;
  assign pop      = Out_Valid && Out_Ready;

  // A concurrent Clear zeroes the accumulator before it is used as an operand.
  assign x_op = Acc ? (Clear ? '0 : acc_q) : A;
  assign b_op = S ? ~B : B;
  assign raw  = {1'b0, x_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, S};
  assign r    = raw[WIDTH-1:0];

  // Subtract carry-out is inverted borrow.
  assign uov = S ? ~raw[WIDTH] : raw[WIDTH];
  assign sov = (S ? (x_op[WIDTH-1] != B[WIDTH-1]) : (x_op[WIDTH-1] == B[WIDTH-1]))
               && (r[WIDTH-1] != x_op[WIDTH-1]);

  always_comb begin
    f_next = r;
    if (SAT_MODE == 1 && uov)
      f_next = S ? '0 : '1;
    else if (SAT_MODE == 2 && sov)
      f_next = x_op[WIDTH-1] ? MIN_NEG : MAX_POS;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Out_Valid         <= 1'b0;
      F                 <= '0;
      Unsigned_Overflow <= 1'b0;
      Signed_Overflow   <= 1'b0;
      Sticky_Unsigned   <= 1'b0;
      Sticky_Signed     <= 1'b0;
      acc_q             <= '0;
    end else if (accept) begin
      Out_Valid         <= 1'b1;
      F                 <= f_next;
      Unsigned_Overflow <= uov;
      Signed_Overflow   <= sov;
      acc_q             <= f_next;
      Sticky_Unsigned   <= (Sticky_Unsigned && !Clear) || uov;
      Sticky_Signed     <= (Sticky_Signed && !Clear) || sov;
    end else begin
      if (pop) Out_Valid <= 1'b0;
      if (Clear) begin
        acc_q           <= '0;
        Sticky_Unsigned <= 1'b0;
        Sticky_Signed   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addsub_accum.sv
// Drives three addsub_accum instances (SAT_MODE 0/1/2) with one stimulus stream and
// compares every output against an integer-arithmetic reference model each cycle.
module tb_addsub_accum;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst, in_valid, s, acc, clear, out_ready;
  logic [W-1:0] a, b;

  logic         in_ready [3];
  logic         out_valid[3];
  logic [W-1:0] f        [3];
  logic         uo       [3];
  logic         so       [3];
  logic         su       [3];
  logic         ss       [3];

  // reference model state per instance
  int m_v[3], m_f[3], m_uo[3], m_so[3], m_acc[3], m_su[3], m_ss[3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  addsub_accum #(.WIDTH(W), .SAT_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .In_Valid(in_valid), .In_Ready(in_ready[0]), .S(s), .Acc(acc),
    .A(a), .B(b), .Clear(clear), .Out_Valid(out_valid[0]), .Out_Ready(out_ready), .F(f[0]),
    .Unsigned_Overflow(uo[0]), .Signed_Overflow(so[0]),
    .Sticky_Unsigned(su[0]), .Sticky_Signed(ss[0]));

  addsub_accum #(.WIDTH(W), .SAT_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .In_Valid(in_valid), .In_Ready(in_ready[1]), .S(s), .Acc(acc),
    .A(a), .B(b), .Clear(clear), .Out_Valid(out_valid[1]), .Out_Ready(out_ready), .F(f[1]),
    .Unsigned_Overflow(uo[1]), .Signed_Overflow(so[1]),
    .Sticky_Unsigned(su[1]), .Sticky_Signed(ss[1]));

  addsub_accum #(.WIDTH(W), .SAT_MODE(2)) dut2 (
    .clk(clk), .rst(rst), .In_Valid(in_valid), .In_Ready(in_ready[2]), .S(s), .Acc(acc),
    .A(a), .B(b), .Clear(clear), .Out_Valid(out_valid[2]), .Out_Ready(out_ready), .F(f[2]),
    .Unsigned_Overflow(uo[2]), .Signed_Overflow(so[2]),
    .Sticky_Unsigned(su[2]), .Sticky_Signed(ss[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: plain integer math on unsigned and signed interpretations.
  task automatic ref_op(input int mode, input int x, input int bv, input int sub,
                        output int fo, output int uof, output int sof);
    int us, sx, sb, sres;
    us  = sub ? x - bv : x + bv;
    uof = (us < 0 || us > 15) ? 1 : 0;
    sx  = (x  >= 8) ? x  - 16 : x;
    sb  = (bv >= 8) ? bv - 16 : bv;
    sres = sub ? sx - sb : sx + sb;
    sof = (sres > 7 || sres < -8) ? 1 : 0;
    fo  = us & 15;
    if (mode == 1 && uof) fo = sub ? 0 : 15;
    if (mode == 2 && sof) fo = (sx >= 0) ? 7 : 8;
  endtask

  task automatic model_step();
    int x, fo, uof, sof;
    for (int m = 0; m < 3; m++) begin
      if (rst) begin
        m_v[m] = 0; m_f[m] = 0; m_uo[m] = 0; m_so[m] = 0;
        m_acc[m] = 0; m_su[m] = 0; m_ss[m] = 0;
      end else if (in_valid && (!m_v[m] || out_ready)) begin
        x = acc ? (clear ? 0 : m_acc[m]) : int'(a);
        ref_op(m, x, int'(b), int'(s), fo, uof, sof);
        m_v[m] = 1; m_f[m] = fo; m_uo[m] = uof; m_so[m] = sof; m_acc[m] = fo;
        m_su[m] = (clear ? 0 : m_su[m]) | uof;
        m_ss[m] = (clear ? 0 : m_ss[m]) | sof;
      end else begin
        if (m_v[m] && out_ready) m_v[m] = 0;
        if (clear) begin m_acc[m] = 0; m_su[m] = 0; m_ss[m] = 0; end
      end
    end
  endtask

  // One clock: apply inputs, check In_Ready, clock, then check all registered outputs.
  task automatic cyc(input logic r, input logic iv, input logic sv, input logic ac,
                     input int av, input int bv, input logic cl, input logic ordy);
    rst = r; in_valid = iv; s = sv; acc = ac; a = av[W-1:0]; b = bv[W-1:0];
    clear = cl; out_ready = ordy;
    #1;
    for (int m = 0; m < 3; m++)
      chk($sformatf("m%0d_in_ready", m), in_ready[m], (!m_v[m] || ordy) ? 1 : 0);
    model_step();
    @(posedge clk); #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("m%0d_out_valid", m), out_valid[m], m_v[m]);
      chk($sformatf("m%0d_F", m),         f[m],         m_f[m]);
      chk($sformatf("m%0d_uov", m),       uo[m],        m_uo[m]);
      chk($sformatf("m%0d_sov", m),       so[m],        m_so[m]);
      chk($sformatf("m%0d_sticky_u", m),  su[m],        m_su[m]);
      chk($sformatf("m%0d_sticky_s", m),  ss[m],        m_ss[m]);
    end
  endtask

  initial begin
    for (int m = 0; m < 3; m++) begin
      m_v[m] = 0; m_f[m] = 0; m_uo[m] = 0; m_so[m] = 0;
      m_acc[m] = 0; m_su[m] = 0; m_ss[m] = 0;
    end
    rst = 1; in_valid = 0; s = 0; acc = 0; a = 0; b = 0; clear = 0; out_ready = 1;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("reset_valid", out_valid[0], 0);
    chk("reset_F", f[0], 0);

    // basic add / sub
    cyc(0, 1, 0, 0, 3, 2, 0, 1); chk("add_3_2", f[0], 5);
    cyc(0, 1, 1, 0, 3, 2, 0, 1); chk("sub_3_2", f[0], 1);

    // overflow corners
    cyc(0, 1, 0, 0, 7, 1, 0, 1);  chk("7p1_F", f[0], 8);  chk("7p1_sov", so[0], 1);
    cyc(0, 1, 0, 0, 15, 1, 0, 1); chk("15p1_F", f[0], 0); chk("15p1_uov", uo[0], 1);
    cyc(0, 1, 1, 0, 2, 3, 0, 1);  chk("2m3_F", f[0], 15); chk("2m3_uov", uo[0], 1);
    cyc(0, 1, 1, 0, 8, 1, 0, 1);  chk("8m1_F", f[0], 7);  chk("8m1_sov", so[0], 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("sticky_u_set", su[0], 1); chk("sticky_s_set", ss[0], 1);

    // backpressure: held result, second beat refused, then pop+accept
    cyc(0, 1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 5, 5, 0, 0);
      chk("bp_F_stable", f[0], 2);
      chk("bp_in_ready", in_ready[0], 0);
    end
    cyc(0, 1, 0, 0, 5, 5, 0, 1);
    chk("pop_accept_valid", out_valid[0], 1); chk("pop_accept_F", f[0], 10);

    // accumulate
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 0, 1, 0, 3, 0, 1);
      chk("accum_F", f[0], 3 * i);
    end
    cyc(0, 1, 1, 1, 0, 13, 0, 1); chk("accum_sub_F", f[0], 15); chk("accum_sub_uov", uo[0], 1);
    cyc(0, 1, 0, 1, 0, 4, 1, 1);
    chk("clr_acc_F", f[0], 4); chk("clr_acc_su", su[0], 0); chk("clr_acc_ss", ss[0], 0);

    // saturation
    cyc(0, 1, 0, 0, 12, 6, 0, 1); chk("usat_add", f[1], 15); chk("usat_add_uov", uo[1], 1);
    cyc(0, 1, 1, 0, 2, 5, 0, 1);  chk("usat_sub", f[1], 0);
    cyc(0, 1, 0, 0, 6, 5, 0, 1);  chk("ssat_add", f[2], 7);  chk("ssat_add_sov", so[2], 1);
    cyc(0, 1, 1, 0, 9, 3, 0, 1);  chk("ssat_sub", f[2], 8);

    // reset mid-transaction, with an input beat offered (reset wins)
    cyc(0, 1, 0, 0, 9, 9, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 3, 3, 0, 0);
    chk("rst_mid_valid", out_valid[0], 0); chk("rst_mid_F", f[0], 0);
    chk("rst_mid_in_ready", in_ready[0], 1);
    cyc(0, 1, 0, 1, 0, 2, 0, 1); chk("rst_acc_zero", f[0], 2);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(63) == 0), $urandom_range(1), $urandom_range(1), $urandom_range(1),
          $urandom_range(15), $urandom_range(15), ($urandom_range(7) == 0),
          ($urandom_range(3) != 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
